ls_axil_initiator: RTL and testbench
====================================

# ls_axil_initiator

AXI4-Lite initiator that drives the low-speed (ls) register port of a user subsystem from a simple single-request command interface. It turns one request into one AXI-Lite write (AW+W) or read (AR then R) transaction and returns a single response. A watchdog aborts any transaction the responder never completes. The block sits between the management/control logic and the user subsystem's ls responder port. The ls responder port has no write-response channel, so a write is complete once both address and data handshakes have occurred.

## Interface
- pADDR_WIDTH, 12, address width of req_addr / m_awaddr / m_araddr
- pDATA_WIDTH, 32, data width; strobe width is pDATA_WIDTH/8
- pTIMEOUT, 255, bus cycles allowed per transaction before abort (1..65535)

Ports:
- axi_clk  in  1  sole clock, all logic on rising edge
- axi_reset  in  1  asynchronous, active-high reset
- req_valid / req_ready  in / out  1  request handshake
- req_write  in  1  1 = write, 0 = read
- req_addr  in  pADDR_WIDTH  target address
- req_wdata  in  pDATA_WIDTH  write data
- req_wstrb  in  pDATA_WIDTH/8  write byte strobes
- rsp_valid / rsp_ready  out / in  1  response handshake
- rsp_rdata  out  pDATA_WIDTH  read data
- rsp_timeout  out  1  transaction aborted by watchdog
- m_awaddr, m_awvalid / m_awready  out, out / in  pADDR_WIDTH, 1 / 1  write address channel
- m_wdata, m_wstrb, m_wvalid / m_wready  out, out, out / in  pDATA_WIDTH, pDATA_WIDTH/8, 1 / 1  write data channel
- m_araddr, m_arvalid / m_arready  out, out / in  pADDR_WIDTH, 1 / 1  read address channel
- m_rdata, m_rvalid / m_rready  in, in / out  pDATA_WIDTH, 1 / 1  read data channel

## Operation
- All outputs are registered.
- Reset values: all outputs 0 and state IDLE. req_ready rises on the first clock edge after axi_reset deasserts.
- Reset asserted mid-transaction aborts immediately. No response is produced and all valids drop asynchronously.
- **IDLE:** req_ready=1. On req_valid&req_ready, latch addr/wdata/wstrb/write and drop req_ready.
  - Write: go to WR with m_awvalid=m_wvalid=1.
  - Read: go to RD_ADDR with m_arvalid=1.
- **WR:** AW and W channels are independent.
  - Each valid drops the cycle after its own handshake.
  - Once both handshakes are done (same cycle or different cycles), go to RESP with rsp_rdata=0 and rsp_timeout=0.
- **RD_ADDR:** m_arvalid is held until m_arready. Then go to RD_DATA with m_rready=1.
  - m_rvalid is ignored in this state.
- **RD_DATA:** on m_rvalid, capture m_rdata into rsp_rdata, drop m_rready, go to RESP with rsp_timeout=0.
- **RESP:** rsp_valid=1 and held, with rsp_rdata and rsp_timeout stable, until rsp_ready. Then return to IDLE.
- Watchdog (16-bit counter):
  - Cleared on entry to WR/RD_ADDR. Increments each cycle in WR, RD_ADDR and RD_DATA.
  - Timeout fires when the counter reaches pTIMEOUT-1 and the pending handshake does not occur in that cycle.
  - On timeout: all m_*valid and m_rready drop, go to RESP with rsp_timeout=1 and rsp_rdata all-ones.
- A handshake that completes in the final allowed cycle takes priority over the timeout.
- Address/data/strobe outputs are stable while their valid is high. Valids are never withdrawn before handshake except on timeout or reset.

## Timing
- Request accepted at edge 0. m_awvalid/m_wvalid/m_arvalid are high from edge 0 (visible cycle 1).
- Write, with ready signals high: handshake in cycle 1, rsp_valid in cycle 2. Minimum request-to-response is 2 cycles.
- Read, with ready signals high and zero-latency rvalid: AR handshake in cycle 1, m_rready in cycle 2, rvalid captured in cycle 2, rsp_valid in cycle 3.
- Any valid is held high for at most pTIMEOUT cycles per transaction.
- Throughput: one outstanding transaction. The next request is accepted the cycle after the rsp handshake.

## Test plan
- Write 0xA5A5_0001, wstrb 0xF, to addr 0x010 with awready=wready=1 -> m_awaddr=0x010 and m_wdata=0xA5A5_0001 in cycle 1; rsp_valid in cycle 2 with rsp_timeout=0.
- Write with wready delayed 3 cycles after awready -> m_awvalid drops after cycle 1; m_wvalid held through the handshake; exactly one rsp.
- Read addr 0x024, arready delayed 2 cycles, rvalid 1 cycle after m_rready with rdata 0xDEAD_BEEF -> rsp_rdata=0xDEAD_BEEF, rsp_timeout=0.
- Read with arready tied 0, pTIMEOUT=8 -> m_arvalid high for exactly 8 cycles; rsp_timeout=1, rsp_rdata=0xFFFF_FFFF; next request accepted afterwards.
- rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_rdata stable and req_ready=0 throughout.
- axi_reset pulsed while in RD_DATA -> all outputs 0 at once; after release, no stray rsp and a new read completes normally.

Source files
------------

// File: rtl/ls_axil_initiator.sv
// ls_axil_initiator: single-request command port to AXI4-Lite initiator for the
// user subsystem ls register port. One transaction in flight; watchdog aborts
// transactions the responder never completes. The ls port has no B channel, so
// a write completes once both AW and W handshakes have occurred.
module ls_axil_initiator #(
    parameter int unsigned pADDR_WIDTH = 12,
    parameter int unsigned pDATA_WIDTH = 32,
    parameter int unsigned pTIMEOUT    = 255
) (
    input  logic                       axi_clk,
    input  logic                       axi_reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [pADDR_WIDTH-1:0]     req_addr,
    input  logic [pDATA_WIDTH-1:0]     req_wdata,
    input  logic [pDATA_WIDTH/8-1:0]   req_wstrb,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [pDATA_WIDTH-1:0]     rsp_rdata,
    output logic                       rsp_timeout,
    output logic [pADDR_WIDTH-1:0]     m_awaddr,
    output logic                       m_awvalid,
    input  logic                       m_awready,
    output logic [pDATA_WIDTH-1:0]     m_wdata,
    output logic [pDATA_WIDTH/8-1:0]   m_wstrb,
    output logic                       m_wvalid,
    input  logic                       m_wready,
    output logic [pADDR_WIDTH-1:0]     m_araddr,
    output logic                       m_arvalid,
    input  logic                       m_arready,
    input  logic [pDATA_WIDTH-1:0]     m_rdata,
    input  logic                       m_rvalid,
    output logic                       m_rready
);

    localparam int unsigned STRB_W   = pDATA_WIDTH / 8;
    localparam logic [15:0] WDOG_LAST = 16'(pTIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_ADDR,
        S_RD_DATA,
        S_RESP
    } state_t;

    state_t                   r_state,       w_state_nxt;
    logic                     r_req_ready,   w_req_ready_nxt;
    logic                     r_awvalid,     w_awvalid_nxt;
    logic                     r_wvalid,      w_wvalid_nxt;
    logic                     r_arvalid,     w_arvalid_nxt;
    logic                     r_rready,      w_rready_nxt;
    logic                     r_rsp_valid,   w_rsp_valid_nxt;
    logic                     r_rsp_timeout, w_rsp_timeout_nxt;
    logic [pDATA_WIDTH-1:0]   r_rsp_rdata,   w_rsp_rdata_nxt;
    logic [pADDR_WIDTH-1:0]   r_awaddr,      w_awaddr_nxt;
    logic [pADDR_WIDTH-1:0]   r_araddr,      w_araddr_nxt;
    logic [pDATA_WIDTH-1:0]   r_wdata,       w_wdata_nxt;
    logic [STRB_W-1:0]        r_wstrb,       w_wstrb_nxt;
    logic                     r_aw_done,     w_aw_done_nxt;
    logic                     r_w_done,      w_w_done_nxt;
    logic [15:0]              r_wdog,        w_wdog_nxt;

    logic w_aw_hs, w_w_hs, w_ar_hs, w_r_hs, w_expired;

    assign req_ready   = r_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_timeout = r_rsp_timeout;
    assign m_awaddr    = r_awaddr;
    assign m_awvalid   = r_awvalid;
    assign m_wdata     = r_wdata;
    assign m_wstrb     = r_wstrb;
    assign m_wvalid    = r_wvalid;
    assign m_araddr    = r_araddr;
    assign m_arvalid   = r_arvalid;
    assign m_rready    = r_rready;

    // State and registered outputs; reset clears everything asynchronously
    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            r_state       <= S_IDLE;
            r_req_ready   <= 1'b0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_rsp_rdata   <= '0;
            r_awaddr      <= '0;
            r_araddr      <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            r_wdog        <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_req_ready   <= w_req_ready_nxt;
            r_awvalid     <= w_awvalid_nxt;
            r_wvalid      <= w_wvalid_nxt;
            r_arvalid     <= w_arvalid_nxt;
            r_rready      <= w_rready_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_timeout <= w_rsp_timeout_nxt;
            r_rsp_rdata   <= w_rsp_rdata_nxt;
            r_awaddr      <= w_awaddr_nxt;
            r_araddr      <= w_araddr_nxt;
            r_wdata       <= w_wdata_nxt;
            r_wstrb       <= w_wstrb_nxt;
            r_aw_done     <= w_aw_done_nxt;
            r_w_done      <= w_w_done_nxt;
            r_wdog        <= w_wdog_nxt;
        end
    end

    // Next-state and next-output logic; handshakes beat the watchdog in the last cycle
    always_comb begin
        w_state_nxt       = r_state;
        w_req_ready_nxt   = r_req_ready;
        w_awvalid_nxt     = r_awvalid;
        w_wvalid_nxt      = r_wvalid;
        w_arvalid_nxt     = r_arvalid;
        w_rready_nxt      = r_rready;
        w_rsp_valid_nxt   = r_rsp_valid;
        w_rsp_timeout_nxt = r_rsp_timeout;
        w_rsp_rdata_nxt   = r_rsp_rdata;
        w_awaddr_nxt      = r_awaddr;
        w_araddr_nxt      = r_araddr;
        w_wdata_nxt       = r_wdata;
        w_wstrb_nxt       = r_wstrb;
        w_aw_done_nxt     = r_aw_done;
        w_w_done_nxt      = r_w_done;
        w_wdog_nxt        = r_wdog;

        w_aw_hs   = r_awvalid & m_awready;
        w_w_hs    = r_wvalid & m_wready;
        w_ar_hs   = r_arvalid & m_arready;
        w_r_hs    = r_rready & m_rvalid;
        w_expired = (r_wdog >= WDOG_LAST);

        case (r_state)
            S_IDLE: begin
                w_req_ready_nxt = 1'b1;
                if (req_valid && r_req_ready) begin
                    w_req_ready_nxt = 1'b0;
                    w_wdog_nxt      = '0;
                    if (req_write) begin
                        w_awaddr_nxt  = req_addr;
                        w_wdata_nxt   = req_wdata;
                        w_wstrb_nxt   = req_wstrb;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                        w_aw_done_nxt = 1'b0;
                        w_w_done_nxt  = 1'b0;
                        w_state_nxt   = S_WR;
                    end else begin
                        w_araddr_nxt  = req_addr;
                        w_arvalid_nxt = 1'b1;
                        w_state_nxt   = S_RD_ADDR;
                    end
                end
            end
            S_WR: begin
                w_wdog_nxt    = r_wdog + 16'd1;
                w_aw_done_nxt = r_aw_done | w_aw_hs;
                w_w_done_nxt  = r_w_done | w_w_hs;
                if (w_aw_hs) w_awvalid_nxt = 1'b0;
                if (w_w_hs)  w_wvalid_nxt  = 1'b0;
                if (w_aw_done_nxt && w_w_done_nxt) begin
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_rdata_nxt   = '0;
                    w_rsp_timeout_nxt = 1'b0;
                    w_state_nxt       = S_RESP;
                end else if (w_expired) begin
                    w_awvalid_nxt     = 1'b0;
                    w_wvalid_nxt      = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_rdata_nxt   = '1;
                    w_rsp_timeout_nxt = 1'b1;
                    w_state_nxt       = S_RESP;
                end
            end
            S_RD_ADDR: begin
                w_wdog_nxt = r_wdog + 16'd1;
                if (w_ar_hs) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = S_RD_DATA;
                end else if (w_expired) begin
                    w_arvalid_nxt     = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_rdata_nxt   = '1;
                    w_rsp_timeout_nxt = 1'b1;
                    w_state_nxt       = S_RESP;
                end
            end
            S_RD_DATA: begin
                w_wdog_nxt = r_wdog + 16'd1;
                if (w_r_hs) begin
                    w_rready_nxt      = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_rdata_nxt   = m_rdata;
                    w_rsp_timeout_nxt = 1'b0;
                    w_state_nxt       = S_RESP;
                end else if (w_expired) begin
                    w_rready_nxt      = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_rdata_nxt   = '1;
                    w_rsp_timeout_nxt = 1'b1;
                    w_state_nxt       = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_req_ready_nxt = 1'b1;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ls_axil_initiator.sv
// Testbench for ls_axil_initiator: table of directed transactions against a
// delay-configurable responder model, plus reset sequences.
module tb_ls_axil_initiator;

    localparam int NEVER = 99;

    logic        axi_clk = 1'b0;
    logic        axi_reset;
    logic        req_valid, req_ready, req_write;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [11:0] m_awaddr, m_araddr;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_arvalid, m_arready;
    logic [31:0] m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic        m_rvalid, m_rready;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        write;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_d;
        int          w_d;
        int          ar_d;
        int          r_d;
        int          rsp_d;
        logic [31:0] rdata;
        int          exp_cyc;
        logic        exp_to;
        logic [31:0] exp_rdata;
        int          exp_aw;
        int          exp_w;
        int          exp_ar;
        int          exp_r;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    ls_axil_initiator #(
        .pADDR_WIDTH(12),
        .pDATA_WIDTH(32),
        .pTIMEOUT   (8)
    ) dut (
        .axi_clk    (axi_clk),
        .axi_reset  (axi_reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_timeout(rsp_timeout),
        .m_awaddr   (m_awaddr),
        .m_awvalid  (m_awvalid),
        .m_awready  (m_awready),
        .m_wdata    (m_wdata),
        .m_wstrb    (m_wstrb),
        .m_wvalid   (m_wvalid),
        .m_wready   (m_wready),
        .m_araddr   (m_araddr),
        .m_arvalid  (m_arvalid),
        .m_arready  (m_arready),
        .m_rdata    (m_rdata),
        .m_rvalid   (m_rvalid),
        .m_rready   (m_rready)
    );

    always #5 axi_clk = ~axi_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        rsp_ready = 1'b0; m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
        m_rvalid  = 1'b0; m_rdata = 32'h0BAD_0BAD;
    endtask

    // One request through the DUT with the responder model answering after per-channel delays
    task automatic run_txn(input int idx);
        vec_t v;
        int awc, wc, arc, rc, rspc;
        int aw_n, w_n, ar_n, r_n, rsp_cyc;
        bit done;
        v = vecs[idx];
        awc = 0; wc = 0; arc = 0; rc = 0; rspc = 0;
        aw_n = 0; w_n = 0; ar_n = 0; r_n = 0; rsp_cyc = -1;
        done = 1'b0;
        @(negedge axi_clk);
        chk("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1; req_write = v.write; req_addr = v.addr;
        req_wdata = v.wdata; req_wstrb = v.wstrb;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge axi_clk);
            req_valid = 1'b0;
            m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
            m_rvalid = 1'b0; m_rdata = 32'h0BAD_0BAD; rsp_ready = 1'b0;
            if (m_awvalid) begin
                chk("awaddr", m_awaddr, v.addr);
                m_awready = (awc == v.aw_d);
                awc++; aw_n++;
            end
            if (m_wvalid) begin
                chk("wdata", m_wdata, v.wdata);
                chk("wstrb", m_wstrb, v.wstrb);
                m_wready = (wc == v.w_d);
                wc++; w_n++;
            end
            if (m_arvalid) begin
                chk("araddr", m_araddr, v.addr);
                m_arready = (arc == v.ar_d);
                arc++; ar_n++;
            end
            if (m_rready) begin
                if (rc == v.r_d) begin
                    m_rvalid = 1'b1;
                    m_rdata  = v.rdata;
                end
                rc++; r_n++;
            end
            chk("req_ready_busy", req_ready, 1'b0);
            if (rsp_valid) begin
                if (rsp_cyc < 0) rsp_cyc = c;
                chk("rsp_rdata", rsp_rdata, v.exp_rdata);
                chk("rsp_timeout", rsp_timeout, v.exp_to);
                rsp_ready = (rspc == v.rsp_d);
                rspc++;
                if (rsp_ready) done = 1'b1;
            end
        end
        if (!done) chk("rsp_within_budget", 32'd0, 32'd1);
        chk("rsp_cycle", rsp_cyc, v.exp_cyc);
        chk("aw_cycles", aw_n, v.exp_aw);
        chk("w_cycles", w_n, v.exp_w);
        chk("ar_cycles", ar_n, v.exp_ar);
        chk("r_cycles", r_n, v.exp_r);
        @(negedge axi_clk);
        clear_inputs();
        chk("rsp_dropped", rsp_valid, 1'b0);
        chk("req_ready_after_rsp", req_ready, 1'b1);
        chk("valids_idle", {m_awvalid, m_wvalid, m_arvalid, m_rready}, 4'b0000);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got no finish, expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        //          wr    addr     wdata          strb  aw     w      ar     r      rsp  rdata          cyc to    exp_rdata      aw w  ar r
        vecs[0] = '{1'b1, 12'h010, 32'hA5A5_0001, 4'hF, 0,     0,     0,     0,     0,   32'h0,         2,  1'b0, 32'h0000_0000, 1, 1, 0, 0};
        vecs[1] = '{1'b1, 12'h014, 32'h0000_1234, 4'h3, 0,     3,     0,     0,     0,   32'h0,         5,  1'b0, 32'h0000_0000, 1, 4, 0, 0};
        vecs[2] = '{1'b0, 12'h024, 32'h0,         4'h0, 0,     0,     2,     1,     2,   32'hDEAD_BEEF, 6,  1'b0, 32'hDEAD_BEEF, 0, 0, 3, 2};
        vecs[3] = '{1'b0, 12'h030, 32'h0,         4'h0, 0,     0,     NEVER, 0,     0,   32'h0,         9,  1'b1, 32'hFFFF_FFFF, 0, 0, 8, 0};
        vecs[4] = '{1'b1, 12'h040, 32'hCAFE_0005, 4'hF, 0,     0,     0,     0,     5,   32'h0,         2,  1'b0, 32'h0000_0000, 1, 1, 0, 0};
        vecs[5] = '{1'b0, 12'h044, 32'h0,         4'h0, 0,     0,     0,     0,     0,   32'h1234_5678, 3,  1'b0, 32'h1234_5678, 0, 0, 1, 1};
        vecs[6] = '{1'b1, 12'h050, 32'h5555_AAAA, 4'hC, 0,     NEVER, 0,     0,     0,   32'h0,         9,  1'b1, 32'hFFFF_FFFF, 1, 8, 0, 0};
        vecs[7] = '{1'b1, 12'h054, 32'h0F0F_0F0F, 4'h1, 0,     7,     0,     0,     0,   32'h0,         9,  1'b0, 32'h0000_0000, 1, 8, 0, 0};
        vecs[8] = '{1'b0, 12'h058, 32'h0,         4'h0, 0,     0,     0,     NEVER, 0,   32'h0,         9,  1'b1, 32'hFFFF_FFFF, 0, 0, 1, 7};
        vecs[9] = '{1'b1, 12'h05C, 32'h8765_4321, 4'hF, 2,     0,     0,     0,     0,   32'h0,         4,  1'b0, 32'h0000_0000, 3, 1, 0, 0};

        clear_inputs();
        axi_reset = 1'b1;
        repeat (2) @(negedge axi_clk);
        chk("rst_ctrl_zero", {m_awvalid, m_wvalid, m_arvalid, m_rready, rsp_valid, rsp_timeout, req_ready}, 7'd0);
        chk("rst_data_zero", 32'(m_awaddr) | 32'(m_araddr) | m_wdata | 32'(m_wstrb) | rsp_rdata, 32'd0);
        axi_reset = 1'b0;
        #1;
        chk("req_ready_before_edge", req_ready, 1'b0);
        @(negedge axi_clk);
        chk("req_ready_first_edge", req_ready, 1'b1);

        for (int i = 0; i < NV; i++) run_txn(i);

        // Reset while waiting for read data: outputs clear at once, no stray response
        @(negedge axi_clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h060;
        @(negedge axi_clk);
        req_valid = 1'b0;
        chk("mr_arvalid", m_arvalid, 1'b1);
        m_arready = 1'b1;
        @(negedge axi_clk);
        m_arready = 1'b0;
        chk("mr_rready", m_rready, 1'b1);
        @(negedge axi_clk);
        chk("mr_rready_held", m_rready, 1'b1);
        axi_reset = 1'b1;
        #1;
        chk("mr_ctrl_zero", {m_awvalid, m_wvalid, m_arvalid, m_rready, rsp_valid, rsp_timeout, req_ready}, 7'd0);
        chk("mr_data_zero", 32'(m_araddr) | rsp_rdata, 32'd0);
        repeat (2) @(negedge axi_clk);
        axi_reset = 1'b0;
        m_rvalid = 1'b1; m_rdata = 32'h5A5A_5A5A;
        for (int c = 0; c < 10; c++) begin
            @(negedge axi_clk);
            if (rsp_valid || m_rready) chk("mr_no_stray", {rsp_valid, m_rready}, 2'b00);
        end
        chk("mr_quiet", {rsp_valid, m_rready, m_arvalid}, 3'b000);
        m_rvalid = 1'b0; m_rdata = 32'h0BAD_0BAD;
        run_txn(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
